// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, data width and bit-time helper.
// Intended for both uart_receiver and uart_transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int COUNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  function automatic int bit_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic [1:0] sync_q;

  // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 mid-bit sampling, valid/ready holding register, framing/overrun flags.
// Define UART_RX_PARITY_EN for an 8E1 frame with a parity check.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       parity_error
);

  localparam int BIT_TIME = bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = BIT_TIME / 2;
  localparam logic [COUNT_W-1:0] BIT_LAST  = COUNT_W'(BIT_TIME - 1);
  localparam logic [COUNT_W-1:0] HALF_LAST = COUNT_W'(HALF_BIT - 1);

  logic               rx_s;
  uart_state_t        state, state_next;
  logic [COUNT_W-1:0] clock_count;
  logic [2:0]         bit_index;
  logic [7:0]         shift_reg;
  logic               count_clr, sample_data, deliver, frame_err;
  logic               bit_done, half_done;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  assign bit_done  = (clock_count == BIT_LAST);
  assign half_done = (clock_count == HALF_LAST);

`ifdef UART_RX_PARITY_EN
  logic sample_parity, parity_err, parity_bad;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    count_clr   = 1'b0;
    sample_data = 1'b0;
    deliver     = 1'b0;
    frame_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_parity = 1'b0;
    parity_err    = 1'b0;
`endif
    case (state)
      IDLE: begin
        count_clr = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (half_done) begin
          count_clr  = 1'b1;
          state_next = rx_s ? IDLE : DATA;   // high at mid start bit is a glitch
        end
      end
      DATA: begin
        if (bit_done) begin
          count_clr   = 1'b1;
          sample_data = 1'b1;
          if (bit_index == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          count_clr     = 1'b1;
          sample_parity = 1'b1;
          state_next    = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          count_clr = 1'b1;
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad) parity_err = 1'b1;
            else            deliver    = 1'b1;
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        count_clr = 1'b1;
        if (rx_s) state_next = IDLE;   // a held-low line must not look like a new start bit
      end
      default: begin
        count_clr  = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clock_count <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
    end else begin
      clock_count <= count_clr ? '0 : clock_count + COUNT_W'(1);
      if (sample_data) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
        bit_index <= bit_index + 3'd1;
      end else if (state != DATA) begin
        bit_index <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= frame_err;
      overrun_error <= deliver && data_valid && !data_ready;
      if (deliver) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits plus the parity bit must XOR to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (sample_parity) parity_bad <= ^{shift_reg, rx_s};
      parity_error <= parity_err;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at BIT_TIME=16; honours UART_RX_PARITY_EN.
module tb_uart_receiver;

  localparam int CLOCK_FREQ = 1600000;
  localparam int BAUD_RATE  = 100000;
  localparam int BIT_TIME   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, framing_error, overrun_error, parity_error;

  int vectors = 0;
  int miscompares = 0;

  int         valid_cycles = 0, valid_rises = 0;
  int         fe_pulses = 0, oe_pulses = 0, pe_pulses = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] cap [0:15];

  always #5 clk = ~clk;

  uart_receiver #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .parity_error  (parity_error)
  );

  // Event monitor sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    prev_valid <= data_valid;
    if (data_valid) begin
      valid_cycles <= valid_cycles + 1;
      last_data    <= data_out;
      cap[valid_cycles % 16] <= data_out;
    end
    if (data_valid && !prev_valid) valid_rises <= valid_rises + 1;
    if (framing_error) fe_pulses <= fe_pulses + 1;
    if (overrun_error) oe_pulses <= oe_pulses + 1;
    if (parity_error)  pe_pulses <= pe_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_TIME) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_TIME) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_raw(input logic [7:0] d, input logic stop_bit, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop_bit);
  endtask
`endif

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; data_ready = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++; $display("FAIL reset_data_out: got %0h, required 00", data_out);
    end
    vectors++;
    if ({data_valid, framing_error, overrun_error, parity_error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 0000",
               {data_valid, framing_error, overrun_error, parity_error});
    end
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_single_byte;
    int vc, fe, oe;
    data_ready = 1'b1;
    vc = valid_cycles; fe = fe_pulses; oe = oe_pulses;
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    vectors++;
    if (valid_cycles - vc !== 1) begin
      miscompares++; $display("FAIL single_valid_cycles: got %0d, required 1", valid_cycles - vc);
    end
    vectors++;
    if (last_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_data: got %0h, required a5", last_data);
    end
    vectors++;
    if ((fe_pulses - fe) + (oe_pulses - oe) !== 0) begin
      miscompares++;
      $display("FAIL single_errors: got %0d, required 0", (fe_pulses - fe) + (oe_pulses - oe));
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_valid_cleared: got %b, required 0", data_valid);
    end
  endtask

  task automatic test_overrun;
    int vr, oe, fe;
    data_ready = 1'b0;
    vr = valid_rises; oe = oe_pulses; fe = fe_pulses;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle_bits(1);
    vectors++;
    if (data_out !== 8'hC3) begin
      miscompares++; $display("FAIL overrun_data: got %0h, required c3", data_out);
    end
    vectors++;
    if (data_valid !== 1'b1) begin
      miscompares++; $display("FAIL overrun_valid_held: got %b, required 1", data_valid);
    end
    vectors++;
    if (oe_pulses - oe !== 1) begin
      miscompares++; $display("FAIL overrun_pulses: got %0d, required 1", oe_pulses - oe);
    end
    vectors++;
    if (valid_rises - vr !== 1 || fe_pulses - fe !== 0) begin
      miscompares++;
      $display("FAIL overrun_rises_fe: got %0d/%0d, required 1/0", valid_rises - vr, fe_pulses - fe);
    end
    data_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++; $display("FAIL overrun_accept: got %b, required 0", data_valid);
    end
  endtask

  task automatic test_framing;
    int vc, fe;
    data_ready = 1'b1;
    vc = valid_cycles; fe = fe_pulses;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40 * BIT_TIME) @(negedge clk);
    vectors++;
    if (fe_pulses - fe !== 1) begin
      miscompares++; $display("FAIL framing_pulses: got %0d, required 1", fe_pulses - fe);
    end
    vectors++;
    if (valid_cycles - vc !== 0) begin
      miscompares++; $display("FAIL framing_no_valid: got %0d, required 0", valid_cycles - vc);
    end
    idle_bits(2);
    vc = valid_cycles;
    send_frame(8'h12, 1'b1);
    idle_bits(2);
    vectors++;
    if (fe_pulses - fe !== 1 || valid_cycles - vc !== 1 || last_data !== 8'h12) begin
      miscompares++;
      $display("FAIL framing_recover: got fe=%0d valid=%0d data=%0h, required fe=1 valid=1 data=12",
               fe_pulses - fe, valid_cycles - vc, last_data);
    end
  endtask

  task automatic test_glitch;
    int vc, fe;
    logic saw_data;
    vc = valid_cycles; fe = fe_pulses; saw_data = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 2 * BIT_TIME; i++) begin
      @(negedge clk);
      if (dut.state == uart_pkg::DATA) saw_data = 1'b1;
    end
    vectors++;
    if (saw_data !== 1'b0) begin
      miscompares++; $display("FAIL glitch_state: reached DATA=%b, required 0", saw_data);
    end
    vectors++;
    if (valid_cycles - vc !== 0 || fe_pulses - fe !== 0) begin
      miscompares++;
      $display("FAIL glitch_events: got valid=%0d fe=%0d, required 0/0", valid_cycles - vc, fe_pulses - fe);
    end
  endtask

  task automatic test_back_to_back;
    int vc;
    logic [7:0] bytes [0:2];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    data_ready = 1'b1;
    vc = valid_cycles;
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
    idle_bits(2);
    vectors++;
    if (valid_cycles - vc !== 3) begin
      miscompares++; $display("FAIL b2b_count: got %0d, required 3", valid_cycles - vc);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cap[(vc + i) % 16] !== bytes[i]) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got %0h, required %0h", i, cap[(vc + i) % 16], bytes[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int vr, fe;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (BIT_TIME / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({data_out, data_valid, framing_error, overrun_error, parity_error} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %0h, required 000",
               {data_out, data_valid, framing_error, overrun_error, parity_error});
    end
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    data_ready = 1'b0;
    vr = valid_rises; fe = fe_pulses;
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    vectors++;
    if (data_out !== 8'h81 || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_rx: got data=%0h valid=%b, required 81/1", data_out, data_valid);
    end
    vectors++;
    if (valid_rises - vr !== 1 || fe_pulses - fe !== 0) begin
      miscompares++;
      $display("FAIL midreset_events: got rises=%0d fe=%0d, required 1/0", valid_rises - vr, fe_pulses - fe);
    end
    data_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int vc, pe, fe;
    data_ready = 1'b1;
    vc = valid_cycles; pe = pe_pulses;
    send_frame_raw(8'h07, 1'b1, 1'b0);
    idle_bits(2);
    vectors++;
    if (pe_pulses - pe !== 1 || valid_cycles - vc !== 0) begin
      miscompares++;
      $display("FAIL parity_bad: got pe=%0d valid=%0d, required 1/0", pe_pulses - pe, valid_cycles - vc);
    end
    vc = valid_cycles; pe = pe_pulses;
    send_frame_raw(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    vectors++;
    if (pe_pulses - pe !== 0 || valid_cycles - vc !== 1 || last_data !== 8'h07) begin
      miscompares++;
      $display("FAIL parity_good: got pe=%0d valid=%0d data=%0h, required 0/1/07",
               pe_pulses - pe, valid_cycles - vc, last_data);
    end
    pe = pe_pulses; fe = fe_pulses;
    send_frame_raw(8'h07, 1'b0, 1'b0);
    idle_bits(2);
    vectors++;
    if (fe_pulses - fe !== 1 || pe_pulses - pe !== 0) begin
      miscompares++;
      $display("FAIL parity_priority: got fe=%0d pe=%0d, required 1/0", fe_pulses - fe, pe_pulses - pe);
    end
`else
    vectors++;
    if (pe_pulses !== 0) begin
      miscompares++; $display("FAIL parity_tied: got %0d pulses, required 0", pe_pulses);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_overrun;
    test_framing;
    test_glitch;
    test_back_to_back;
    test_reset_mid_frame;
    test_parity;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
